// File: rtl/matrix_multiplier_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matrix_multiplier_pkg;

    // Control FSM states of the multiplier
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result width that can hold K full-scale products without overflow
    function automatic int c_width_default(input int data_width, input int k);
        return (2 * data_width) + $clog2(k);
    endfunction

    // Extend a 'width'-bit value held in the low bits of a 64-bit word,
    // sign-extending when sgn is set and zero-extending otherwise
    function automatic logic [63:0] extend_to_64(input logic [63:0] val,
                                                 input int          width,
                                                 input logic        sgn);
        logic [63:0] upper_mask;
        logic        msb;
        upper_mask = ~64'd0 << width;
        msb        = |(val & (64'd1 << (width - 1)));
        if (sgn && msb) begin
            return val | upper_mask;
        end
        return val & ~upper_mask;
    endfunction

endpackage

// File: rtl/matrix_multiplier_mac.sv
// One C element: multiply-accumulate register with clear and enable.
// Latency: one product folded into the accumulator per enabled clock.
// Backpressure: none; enable is driven by the parent FSM.
module matrix_multiplier_mac
    import matrix_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int C_DATA_WIDTH = 18,
    parameter int SIGNED       = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [C_DATA_WIDTH-1:0] acc_o
);

    localparam logic IS_SIGNED = (SIGNED != 0);

    logic [2*DATA_WIDTH-1:0]  a_ext;
    logic [2*DATA_WIDTH-1:0]  b_ext;
    logic [2*DATA_WIDTH-1:0]  prod;
    logic [C_DATA_WIDTH-1:0]  acc_q;

    // Full-width product; operands pre-extended so the low 2*DW bits are exact in both modes
    always_comb begin
        a_ext = {{DATA_WIDTH{IS_SIGNED & a_i[DATA_WIDTH-1]}}, a_i};
        b_ext = {{DATA_WIDTH{IS_SIGNED & b_i[DATA_WIDTH-1]}}, b_i};
        prod  = a_ext * b_ext;
    end

    // Accumulator: reset/clear win over enable; narrow result widths wrap naturally
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + C_DATA_WIDTH'(extend_to_64(64'(prod), 2 * DATA_WIDTH, IS_SIGNED));
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matrix_multiplier_seq.sv
// Sequential C = A x B, one MAC per C element, one inner-product term per clock.
// Latency: K cycles from accept to valid_o; one job per K+2 cycles with ready_i high.
// Backpressure: result and valid_o held while ready_i low; ready_o only high in IDLE.
// Optional MATRIX_MULTIPLIER_ACCUMULATE_EN adds accumulate_i (C = C_prev + A x B).
// Element n of every flat matrix bus sits at bits [n*W +: W], row-major order.
module matrix_multiplier_seq
    import matrix_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int A_ROWS           = 8,
    parameter int B_COLUMNS        = 5,
    parameter int A_COLUMNS_B_ROWS = 4,
    parameter int SIGNED           = 0,
    parameter int C_DATA_WIDTH     = c_width_default(DATA_WIDTH, A_COLUMNS_B_ROWS)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
`ifdef MATRIX_MULTIPLIER_ACCUMULATE_EN
    input  logic                                          accumulate_i,
`endif
    input  logic [DATA_WIDTH*A_ROWS*A_COLUMNS_B_ROWS-1:0] a_i,
    input  logic [DATA_WIDTH*A_COLUMNS_B_ROWS*B_COLUMNS-1:0] b_i,
    output logic                                          valid_o,
    input  logic                                          ready_i,
    output logic [C_DATA_WIDTH*A_ROWS*B_COLUMNS-1:0]      c_o,
    output logic                                          busy_o
);

    localparam int K  = A_COLUMNS_B_ROWS;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = DATA_WIDTH * A_ROWS * K;
    localparam int BW = DATA_WIDTH * K * B_COLUMNS;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic            accept;
    logic            clear_acc;
    logic            last_k;

    logic [DATA_WIDTH-1:0] a_col [A_ROWS];
    logic [DATA_WIDTH-1:0] b_row [B_COLUMNS];

    assign accept  = valid_i && (state_q == IDLE);
    assign last_k  = (k_q == KW'(K - 1));
    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == CALC);
    assign valid_o = (state_q == DONE);

`ifdef MATRIX_MULTIPLIER_ACCUMULATE_EN
    assign clear_acc = accept && !accumulate_i;
`else
    assign clear_acc = accept;
`endif

    // Control FSM and inner-dimension counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        state_q <= CALC;
                        k_q     <= '0;
                    end
                end
                CALC: begin
                    if (last_k) begin
                        state_q <= DONE;
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    k_q     <= '0;
                end
            endcase
        end
    end

    // Operand capture; only the accept handshake loads these, so later input changes are ignored
    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    // Column k of A and row k of B, shared by all MACs of the same row / column
    always_comb begin
        for (int i = 0; i < A_ROWS; i++) begin
            a_col[i] = DATA_WIDTH'(a_q >> (((i * K) + int'(k_q)) * DATA_WIDTH));
        end
        for (int j = 0; j < B_COLUMNS; j++) begin
            b_row[j] = DATA_WIDTH'(b_q >> (((int'(k_q) * B_COLUMNS) + j) * DATA_WIDTH));
        end
    end

    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < B_COLUMNS; gj++) begin : g_col
            matrix_multiplier_mac #(
                .DATA_WIDTH   (DATA_WIDTH),
                .C_DATA_WIDTH (C_DATA_WIDTH),
                .SIGNED       (SIGNED)
            ) u_mac (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .clear_i (clear_acc),
                .en_i    (busy_o),
                .a_i     (a_col[gi]),
                .b_i     (b_row[gj]),
                .acc_o   (c_o[((gi * B_COLUMNS) + gj) * C_DATA_WIDTH +: C_DATA_WIDTH])
            );
        end
    end

endmodule
